// File: rtl/fb_port_ctrl.sv
// fb_port_ctrl: byte-stream command sequencer that owns framebuffer/palette port A.
// Define FB_PORT_CTRL_TIMEOUT_EN to abort stalled commands after TIMEOUT_CYCLES idle cycles.
`timescale 1ns/1ps
module fb_port_ctrl #(
    parameter int unsigned FB_SIZE = 76800
`ifdef FB_PORT_CTRL_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_byte,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_byte,
    output logic [16:0] fb_addr,
    output logic [7:0]  fb_wdata,
    output logic        fb_wren,
    input  logic [7:0]  fb_rdata,
    output logic [7:0]  pal_addr,
    output logic [23:0] pal_wdata,
    output logic        pal_wren,
    input  logic [23:0] pal_rdata,
    output logic        busy,
    output logic        err
);

    typedef enum logic [3:0] {
        IDLE,
        HDR,
        WR_DATA,
        RD_ISSUE,
        RD_WAIT,
        RD_RSP,
        PAL_COLLECT,
        PAL_RD_ISSUE,
        PAL_RD_WAIT,
        PAL_RSP,
        FILL
    } state_t;

    localparam logic [16:0] LAST_ADDR = 17'(FB_SIZE - 1);

    state_t      state;
    logic [2:0]  op;
    logic [2:0]  hdr_cnt;
    logic [31:0] hdr_sr;
    logic [16:0] cur;
    logic [15:0] len;
    logic [7:0]  fill_val;
    logic [15:0] rgb_sr;

    logic        cmd_fire;
    logic        rsp_fire;
    logic        to_hit;
    logic [16:0] cur_next;
    logic [39:0] hdr_full;
    logic [23:0] hdr_addr;
    logic [15:0] hdr_len;
    logic        addr_bad;

    assign cmd_ready = (state == IDLE) || (state == HDR) ||
                       (state == WR_DATA) || (state == PAL_COLLECT);
    assign busy      = (state != IDLE);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign rsp_fire  = rsp_valid && rsp_ready;
    assign cur_next  = (cur == LAST_ADDR) ? '0 : cur + 17'd1;
    assign hdr_full  = {hdr_sr, cmd_byte};
    assign hdr_addr  = hdr_full[39:16];
    assign hdr_len   = hdr_full[15:0];
    assign addr_bad  = ({8'h00, hdr_addr} >= FB_SIZE);

`ifdef FB_PORT_CTRL_TIMEOUT_EN
    logic [31:0] to_cnt;
    logic        to_watch;

    assign to_watch = (state == HDR) || (state == WR_DATA) || (state == PAL_COLLECT) ||
                      (state == RD_RSP) || (state == PAL_RSP);
    assign to_hit   = to_watch && !cmd_fire && !rsp_fire && (to_cnt >= TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (!to_watch || cmd_fire || rsp_fire) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 32'd1;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op        <= '0;
            hdr_cnt   <= '0;
            hdr_sr    <= '0;
            cur       <= '0;
            len       <= '0;
            fill_val  <= '0;
            rgb_sr    <= '0;
            rsp_valid <= 1'b0;
            rsp_byte  <= '0;
            fb_addr   <= '0;
            fb_wdata  <= '0;
            fb_wren   <= 1'b0;
            pal_addr  <= '0;
            pal_wdata <= '0;
            pal_wren  <= 1'b0;
            err       <= 1'b0;
        end else begin
            fb_wren  <= 1'b0;
            pal_wren <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        case (cmd_byte)
                            8'h01, 8'h02: begin
                                op      <= cmd_byte[2:0];
                                hdr_cnt <= 3'd5;
                                state   <= HDR;
                            end
                            8'h03, 8'h04, 8'h05: begin
                                op      <= cmd_byte[2:0];
                                hdr_cnt <= 3'd1;
                                state   <= HDR;
                            end
                            default: err <= 1'b1;
                        endcase
                    end
                end
                HDR: begin
                    if (cmd_fire) begin
                        hdr_sr  <= {hdr_sr[23:0], cmd_byte};
                        hdr_cnt <= hdr_cnt - 3'd1;
                        if (hdr_cnt == 3'd1) begin
                            case (op)
                                3'd1, 3'd2: begin
                                    // Reads present the address on entry to RD_ISSUE so the
                                    // 1-cycle RAM latency lands exactly in RD_WAIT.
                                    cur     <= hdr_addr[16:0];
                                    len     <= hdr_len;
                                    fb_addr <= hdr_addr[16:0];
                                    if (addr_bad) begin
                                        err   <= 1'b1;
                                        state <= IDLE;
                                    end else if (hdr_len == 16'd0) begin
                                        state <= IDLE;
                                    end else begin
                                        state <= (op == 3'd1) ? WR_DATA : RD_ISSUE;
                                    end
                                end
                                3'd3: begin
                                    pal_addr <= cmd_byte;
                                    hdr_cnt  <= 3'd3;
                                    state    <= PAL_COLLECT;
                                end
                                3'd4: begin
                                    pal_addr <= cmd_byte;
                                    state    <= PAL_RD_ISSUE;
                                end
                                default: begin
                                    fill_val <= cmd_byte;
                                    cur      <= '0;
                                    state    <= FILL;
                                end
                            endcase
                        end
                    end
                end
                WR_DATA: begin
                    if (cmd_fire) begin
                        fb_wren  <= 1'b1;
                        fb_addr  <= cur;
                        fb_wdata <= cmd_byte;
                        cur      <= cur_next;
                        len      <= len - 16'd1;
                        if (len == 16'd1) state <= IDLE;
                    end
                end
                RD_ISSUE: begin
                    fb_addr <= cur;
                    state   <= RD_WAIT;
                end
                RD_WAIT: begin
                    rsp_byte  <= fb_rdata;
                    rsp_valid <= 1'b1;
                    state     <= RD_RSP;
                end
                RD_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cur       <= cur_next;
                        fb_addr   <= cur_next;
                        len       <= len - 16'd1;
                        state     <= (len == 16'd1) ? IDLE : RD_ISSUE;
                    end
                end
                PAL_COLLECT: begin
                    if (cmd_fire) begin
                        pal_wdata <= {pal_wdata[15:0], cmd_byte};
                        hdr_cnt   <= hdr_cnt - 3'd1;
                        if (hdr_cnt == 3'd1) begin
                            pal_wren <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                end
                PAL_RD_ISSUE: state <= PAL_RD_WAIT;
                PAL_RD_WAIT: begin
                    rsp_byte  <= pal_rdata[23:16];
                    rgb_sr    <= pal_rdata[15:0];
                    rsp_valid <= 1'b1;
                    hdr_cnt   <= 3'd2;
                    state     <= PAL_RSP;
                end
                PAL_RSP: begin
                    if (rsp_ready) begin
                        if (hdr_cnt == 3'd0) begin
                            rsp_valid <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            rsp_byte <= rgb_sr[15:8];
                            rgb_sr   <= {rgb_sr[7:0], 8'h00};
                            hdr_cnt  <= hdr_cnt - 3'd1;
                        end
                    end
                end
                FILL: begin
                    fb_wren  <= 1'b1;
                    fb_addr  <= cur;
                    fb_wdata <= fill_val;
                    cur      <= cur_next;
                    if (cur == LAST_ADDR) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (to_hit) begin
                state     <= IDLE;
                err       <= 1'b1;
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fb_port_ctrl.sv
// Self-checking bench for fb_port_ctrl: directed steps plus random commands against a byte-array model.
`timescale 1ns/1ps
module tb_fb_port_ctrl;

    localparam int unsigned FB_SIZE = 76800;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_byte;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_byte;
    logic [16:0] fb_addr;
    logic [7:0]  fb_wdata;
    logic        fb_wren;
    logic [7:0]  fb_rdata;
    logic [7:0]  pal_addr;
    logic [23:0] pal_wdata;
    logic        pal_wren;
    logic [23:0] pal_rdata;
    logic        busy;
    logic        err;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    fb_port_ctrl #(.FB_SIZE(FB_SIZE)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_byte(cmd_byte),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_byte(rsp_byte),
        .fb_addr(fb_addr), .fb_wdata(fb_wdata), .fb_wren(fb_wren), .fb_rdata(fb_rdata),
        .pal_addr(pal_addr), .pal_wdata(pal_wdata), .pal_wren(pal_wren), .pal_rdata(pal_rdata),
        .busy(busy), .err(err)
    );

    // Synchronous RAMs standing in for the framebuffer and palette (1-cycle read latency).
    logic [7:0]  fb_mem  [FB_SIZE];
    logic [23:0] pal_mem [256];
    initial begin
        for (int i = 0; i < int'(FB_SIZE); i++) fb_mem[i] = 8'h00;
        for (int i = 0; i < 256; i++) pal_mem[i] = 24'h0;
        forever begin
            @(posedge clk);
            if (fb_wren) fb_mem[fb_addr] <= fb_wdata;
            fb_rdata <= fb_mem[fb_addr];
            if (pal_wren) pal_mem[pal_addr] <= pal_wdata;
            pal_rdata <= pal_mem[pal_addr];
        end
    end

    typedef struct packed {
        logic [16:0] addr;
        logic [7:0]  data;
        logic        rdy;
    } wr_t;

    wr_t         wr_q  [$];
    logic [31:0] pal_q [$];

    always @(negedge clk) begin
        if (fb_wren === 1'b1) wr_q.push_back('{addr: fb_addr, data: fb_wdata, rdy: cmd_ready});
        if (pal_wren === 1'b1) pal_q.push_back({pal_addr, pal_wdata});
    end

    // Reference model: plain byte arrays updated from the command semantics.
    logic [7:0]  ref_fb  [FB_SIZE];
    logic [23:0] ref_pal [256];
    logic [7:0]  dq [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        cmd_byte  = b;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("cmd_accept", 32'(n < 200), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int unsigned bound);
        int unsigned n = 0;
        while (busy !== 1'b0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", 32'(n < bound), 32'd1);
        @(negedge clk);
    endtask

    task automatic recv_check(input string tag, input logic [7:0] exp, input int hold);
        int n = 0;
        while (rsp_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rsp_wait", 32'(n < 200), 32'd1);
        check(tag, 32'(rsp_byte), 32'(exp));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("rsp_hold", {23'd0, rsp_valid, rsp_byte}, {23'd0, 1'b1, exp});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic send_px_hdr(input logic [7:0] opc, input int unsigned a, input int unsigned n);
        send_byte(opc);
        send_byte(8'(a >> 16));
        send_byte(8'(a >> 8));
        send_byte(8'(a));
        send_byte(8'(n >> 8));
        send_byte(8'(n));
    endtask

    task automatic cmd_write(input int unsigned a, input int unsigned n);
        int unsigned k;
        send_px_hdr(8'h01, a, n);
        for (int unsigned i = 0; i < n; i++) send_byte(dq[i]);
        wait_idle(100);
        check("wr_count", wr_q.size(), n);
        for (int unsigned i = 0; i < n && wr_q.size() > 0; i++) begin
            wr_t e = wr_q.pop_front();
            k = (a + i) % FB_SIZE;
            check("wr_addr", 32'(e.addr), k);
            check("wr_data", 32'(e.data), 32'(dq[i]));
        end
        for (int unsigned i = 0; i < n; i++) ref_fb[(a + i) % FB_SIZE] = dq[i];
        wr_q.delete();
    endtask

    task automatic cmd_read(input int unsigned a, input int unsigned n, input int hold);
        send_px_hdr(8'h02, a, n);
        for (int unsigned i = 0; i < n; i++) recv_check("rd_data", ref_fb[(a + i) % FB_SIZE], hold);
        wait_idle(100);
        check("rd_nowrite", wr_q.size(), 0);
        wr_q.delete();
    endtask

    task automatic cmd_pal_write(input logic [7:0] idx, input logic [23:0] rgb);
        send_byte(8'h03);
        send_byte(idx);
        send_byte(rgb[23:16]);
        send_byte(rgb[15:8]);
        send_byte(rgb[7:0]);
        wait_idle(100);
        check("palw_count", pal_q.size(), 1);
        if (pal_q.size() > 0) check("palw_entry", pal_q.pop_front(), {idx, rgb});
        ref_pal[idx] = rgb;
        pal_q.delete();
    endtask

    task automatic cmd_pal_read(input logic [7:0] idx, input int hold);
        logic [23:0] e;
        e = ref_pal[idx];
        send_byte(8'h04);
        send_byte(idx);
        recv_check("palr_r", e[23:16], hold);
        recv_check("palr_g", e[15:8], hold);
        recv_check("palr_b", e[7:0], hold);
        wait_idle(100);
        check("palr_nowrite", pal_q.size(), 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_byte",  32'(rsp_byte), 0);
        check("rst_fb_addr",   32'(fb_addr), 0);
        check("rst_fb_wdata",  32'(fb_wdata), 0);
        check("rst_fb_wren",   32'(fb_wren), 0);
        check("rst_pal_addr",  32'(pal_addr), 0);
        check("rst_pal_wdata", 32'(pal_wdata), 0);
        check("rst_pal_wren",  32'(pal_wren), 0);
        check("rst_err",       32'(err), 0);
        check("rst_busy",      32'(busy), 0);
        check("rst_cmd_ready", 32'(cmd_ready), 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned a, n, bad, sel;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_byte  = 8'h00;
        rsp_ready = 1'b0;
        for (int i = 0; i < int'(FB_SIZE); i++) ref_fb[i] = 8'h00;
        for (int i = 0; i < 256; i++) ref_pal[i] = 24'h0;

        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs();

        // Basic burst write
        dq = '{8'hAA, 8'hBB, 8'hCC};
        cmd_write(32'h10, 3);
        check("busy_after_wr", 32'(busy), 0);
        check("err_clean", 32'(err), 0);

        // Address wrap at the last framebuffer byte
        dq = '{8'h11, 8'h22};
        cmd_write(FB_SIZE - 1, 2);

        // len = 0 is a no-op for both write and read
        send_px_hdr(8'h01, 32'h20, 0);
        check("len0_wr_idle", 32'(busy), 0);
        send_px_hdr(8'h02, 32'h20, 0);
        check("len0_rd_idle", 32'(busy), 0);
        repeat (4) @(negedge clk);
        check("len0_rd_norsp", 32'(rsp_valid), 0);
        check("len0_nowrite", wr_q.size(), 0);
        check("len0_err", 32'(err), 0);

        // Read with back-pressure
        dq = '{8'h5A};
        cmd_write(5, 1);
        cmd_read(5, 1, 10);
        cmd_read(FB_SIZE - 1, 2, 1);

        // Palette write then read back
        cmd_pal_write(8'h07, 24'h123456);
        cmd_pal_read(8'h07, 2);

        // Randomised command mix
        for (int it = 0; it < 40; it++) begin
            sel = $urandom_range(0, 3);
            a = ($urandom_range(0, 3) == 0) ? FB_SIZE - $urandom_range(1, 4) : $urandom_range(0, FB_SIZE - 1);
            case (sel)
                0: begin
                    n = $urandom_range(1, 8);
                    dq.delete();
                    for (int unsigned i = 0; i < n; i++) dq.push_back(8'($urandom));
                    cmd_write(a, n);
                end
                1: cmd_read(a, $urandom_range(1, 6), $urandom_range(0, 3));
                2: cmd_pal_write(8'($urandom), 24'($urandom));
                default: cmd_pal_read(($urandom_range(0, 1) == 0) ? 8'h07 : 8'($urandom), $urandom_range(0, 2));
            endcase
        end
        check("err_after_rand", 32'(err), 0);

        // Full-screen fill
        send_byte(8'h05);
        send_byte(8'h3C);
        check("fill_ready_low", 32'(cmd_ready), 0);
        wait_idle(FB_SIZE + 100);
        check("fill_count", wr_q.size(), FB_SIZE);
        bad = 0;
        for (int unsigned i = 0; i < FB_SIZE; i++) begin
            wr_t e;
            if (wr_q.size() == 0) break;
            e = wr_q.pop_front();
            if (e.addr !== 17'(i) || e.data !== 8'h3C || (i < FB_SIZE - 1 && e.rdy !== 1'b0)) bad++;
        end
        check("fill_pattern", bad, 0);
        wr_q.delete();
        for (int unsigned i = 0; i < FB_SIZE; i++) ref_fb[i] = 8'h3C;
        cmd_read(0, 2, 0);
        cmd_read(FB_SIZE - 1, 1, 0);
        cmd_read($urandom_range(0, FB_SIZE - 1), 3, 0);

        // Invalid opcode, then out-of-range header address
        send_byte(8'h9F);
        check("badop_err", 32'(err), 1);
        check("badop_idle", 32'(busy), 0);
        send_px_hdr(8'h01, 32'h020000, 1);
        check("badaddr_idle", 32'(busy), 0);
        check("badaddr_ready", 32'(cmd_ready), 1);
        repeat (3) @(negedge clk);
        check("badaddr_nowrite", wr_q.size(), 0);
        check("badaddr_err", 32'(err), 1);

        // Reset in the middle of WRITE_PAL
        send_byte(8'h03);
        send_byte(8'h09);
        send_byte(8'hAA);
        send_byte(8'hBB);
        check("midpal_busy", 32'(busy), 1);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("midpal_nowrite", pal_q.size(), 0);
        cmd_pal_read(8'h09, 0);
        check("err_after_reset", 32'(err), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fb_port_ctrl.md
Name: fb_port_ctrl

Overview:
Single-clock command sequencer that owns port A of the 320x240 8-bit framebuffer and its 256x24-bit palette. It accepts a byte-stream command protocol from the SPI slave front-end and turns it into framebuffer/palette reads and writes: burst pixel writes and reads, palette entry writes and reads, and a hardware full-screen fill. It is the only master of port A; port B (the pixel scan-out) is unaffected.

Parameters:
FB_SIZE, 76800, framebuffer depth in bytes; the last valid address is FB_SIZE-1.
TIMEOUT_CYCLES, 1000000, idle-byte limit mid-command (used only with the optional feature).

Ports:
clk  in  1  system clock; drives both clk_rgb and clk_palette of the framebuffer.
rst_n  in  1  asynchronous, active-low reset.
cmd_valid  in  1  command byte valid.
cmd_ready  out  1  controller accepts the byte; a transfer occurs when valid&&ready.
cmd_byte  in  8  command/header/data byte.
rsp_valid  out  1  response byte valid.
rsp_ready  in  1  consumer accepts the response byte.
rsp_byte  out  8  read-back byte.
fb_addr  out  17  framebuffer address (rgb_addr).
fb_wdata  out  8  framebuffer write data.
fb_wren  out  1  framebuffer write strobe.
fb_rdata  in  8  framebuffer read data, valid 1 cycle after the address with wren=0.
pal_addr  out  8  palette index.
pal_wdata  out  24  palette write data {R,G,B}.
pal_wren  out  1  palette write strobe.
pal_rdata  in  24  palette read data, 1-cycle latency.
busy  out  1  high in every state except IDLE.
err  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset: state=IDLE; all registered outputs are 0 (rsp_valid, rsp_byte, fb_*, pal_*, err). cmd_ready is combinational and is 1 in IDLE, HDR, WR_DATA and PAL_COLLECT, 0 otherwise. A reset mid-command aborts immediately and no partial palette write is issued.
- Opcodes, with multi-byte fields sent MSB first:
  - 0x01 WRITE_PX: addr[3 bytes, low 17 bits used], len[2 bytes], then len data bytes.
  - 0x02 READ_PX: addr[3 bytes], len[2 bytes]; returns len bytes.
  - 0x03 WRITE_PAL: idx, R, G, B.
  - 0x04 READ_PAL: idx; returns R, G, B.
  - 0x05 FILL: value.
  - Any other opcode: set err, stay in IDLE, and discard the byte.
- Length rules: len=0 is a no-op, and the controller returns to IDLE right after the header. A header addr >= FB_SIZE sets err and aborts to IDLE.
- States:
  - IDLE -> HDR on a valid opcode.
  - HDR: counts header bytes; after the last header byte it moves to WR_DATA, RD_ISSUE, PAL_COLLECT (WRITE_PAL), PAL_RD_ISSUE or FILL.
  - WR_DATA: each accepted byte drives fb_wren=1, fb_addr=cur, fb_wdata=byte for exactly one cycle, registered, so the write is presented the cycle after acceptance. Then cur increments and wraps FB_SIZE-1 -> 0, and len decrements. After the last byte the state returns to IDLE.
  - RD_ISSUE: fb_addr=cur with fb_wren=0 -> RD_WAIT. RD_WAIT captures fb_rdata into rsp_byte and sets rsp_valid -> RD_RSP. RD_RSP holds rsp_byte stable until rsp_ready, then increments/wraps cur and decrements len -> RD_ISSUE, or IDLE after the last byte. Read throughput is at most 1 byte per 3 cycles.
  - PAL_COLLECT: shifts R, G, B into pal_wdata. After B, pal_wren pulses 1 cycle with pal_addr=idx -> IDLE.
  - PAL_RD_ISSUE -> PAL_RD_WAIT, which latches pal_rdata -> PAL_RSP, which sends R, G, B as three handshaked bytes -> IDLE.
  - FILL: one write per cycle, addresses 0..FB_SIZE-1 with fb_wdata=value, exactly FB_SIZE cycles of fb_wren=1 -> IDLE.
- Write strobes: fb_wren and pal_wren are never high at the same time as the corresponding read capture. Outside write cycles fb_wren and pal_wren are 0.
- Address/counter widths: addresses are 17-bit and len is 16-bit, with no overflow beyond the wrap rule above.

Optional Feature:
FB_PORT_CTRL_TIMEOUT_EN.
- Defined: a counter resets on every accepted cmd byte and on every rsp handshake. If TIMEOUT_CYCLES elapse while in HDR, WR_DATA, PAL_COLLECT or any RSP state, the controller sets err, drops rsp_valid, and returns to IDLE. A partial palette write is never issued. FILL is exempt.
- Undefined: there is no counter, and the controller waits indefinitely.

Test Plan:
- Reset, then send 01 00 00 10 00 03 AA BB CC -> fb_wren pulses at addresses 0x10, 0x11, 0x12 with data AA, BB, CC; busy returns to 0; err=0.
- Write 01 01 2B FF 00 02 11 22 (addr 76799) -> writes 11@76799, then 22@0, the wrap.
- With the model holding [5]=0x5A, send 02 00 00 05 00 01 while rsp_ready is held low 10 cycles -> rsp_byte=5A is held stable with rsp_valid=1 until the handshake; then IDLE.
- Send 03 07 12 34 56, then 04 07 -> one pal_wren pulse with addr 7, data 0x123456; read returns 12, 34, 56.
- Send 05 3C -> exactly 76800 consecutive write cycles at addresses 0..76799 with data 3C; cmd_ready stays 0 throughout.
- Send opcode 0x9F, then 01 02 00 00 … (addr 131072) -> err=1 after 0x9F, and the second command aborts with no fb_wren; assert rst_n mid-WRITE_PAL -> outputs return to 0 asynchronously and no pal_wren is issued.
